// File: rtl/turn_switch_conditioner.sv
// Input stage for the taillight controller: synchronises and debounces the raw
// lever/hazard contacts, then arbitrates them into one clean request with a change strobe.
module turn_switch_conditioner #(
    parameter int DEBOUNCE_CYCLES = 125,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic left_raw,
    input  logic right_raw,
    input  logic haz_raw,
    output logic left,
    output logic right,
    output logic haz,
    output logic evt
);

    typedef enum logic [1:0] {
        IDLE,
        LEFT,
        RIGHT,
        HAZ
    } state_t;

    // Channel order everywhere below: bit 0 = left, bit 1 = right, bit 2 = hazard.
    logic [2:0] raw;
    logic [2:0] s1;
    logic [2:0] s2;
    logic [2:0] stable;
    state_t     state;
    state_t     nxt;

    assign raw = {haz_raw, right_raw, left_raw};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // A change is accepted only after DEBOUNCE_CYCLES consecutive mismatching samples.
    // Any return to the stable value clears the count.
    for (genvar i = 0; i < 3; i++) begin : g_deb
        logic [CNT_W-1:0] cnt;
        logic             st;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt <= '0;
                st  <= 1'b0;
            end else if (s2[i] == st) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                st  <= s2[i];
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign stable[i] = st;
    end

    // Both levers at once is treated as a hazard request, so left and right stay exclusive.
    always_comb begin
        nxt = IDLE;
        if (stable[2] || (stable[0] && stable[1])) begin
            nxt = HAZ;
        end else if (stable[0]) begin
            nxt = LEFT;
        end else if (stable[1]) begin
            nxt = RIGHT;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            left  <= 1'b0;
            right <= 1'b0;
            haz   <= 1'b0;
            evt   <= 1'b0;
        end else begin
            state <= nxt;
            left  <= (nxt == LEFT);
            right <= (nxt == RIGHT);
            haz   <= (nxt == HAZ);
            evt   <= (nxt != state);
        end
    end

endmodule

// File: tb/tb_turn_switch_conditioner.sv
// Directed bench for turn_switch_conditioner with DEBOUNCE_CYCLES=4, so a held
// raw change reaches the outputs on the 7th clock edge after it is driven.
module tb_turn_switch_conditioner;

    logic clk;
    logic rst;
    logic left_raw;
    logic right_raw;
    logic haz_raw;
    logic left;
    logic right;
    logic haz;
    logic evt;

    int errors = 0;
    int checks = 0;

    turn_switch_conditioner #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .left_raw (left_raw),
        .right_raw(right_raw),
        .haz_raw  (haz_raw),
        .left     (left),
        .right    (right),
        .haz      (haz),
        .evt      (evt)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic l, input logic r, input logic h);
        left_raw  = l;
        right_raw = r;
        haz_raw   = h;
    endtask

    // Advance to 1 time unit after the next rising edge; inputs are also driven there.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // expHRL = {haz,right,left}
    task automatic checkOutput(input string tag, input logic [2:0] expHRL, input logic expEvt);
        logic [3:0] obs;
        logic [3:0] expv;
        obs  = {haz, right, left, evt};
        expv = {expHRL, expEvt};
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: haz/right/left/evt got %b required %b", tag, obs, expv);
        end
    endtask

    task automatic expectSteady(input string tag, input int n, input logic [2:0] expHRL);
        for (int i = 0; i < n; i++) begin
            step();
            checkOutput(tag, expHRL, 1'b0);
        end
    endtask

    task automatic expectChange(input string tag, input logic [2:0] expHRL);
        step();
        checkOutput(tag, expHRL, 1'b1);
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1);

        // 1: reset with every switch active, then release while held
        #1;
        checkOutput("t1_in_reset", 3'b000, 1'b0);
        expectSteady("t1_reset_edges", 2, 3'b000);
        rst = 1'b1;
        expectSteady("t1_latency", 6, 3'b000);
        expectChange("t1_haz_on", 3'b100);
        expectSteady("t1_haz_hold", 2, 3'b100);
        applyStimulus(1'b0, 1'b0, 1'b0);
        expectSteady("t1_release_wait", 6, 3'b100);
        expectChange("t1_idle", 3'b000);
        expectSteady("t1_idle_hold", 2, 3'b000);

        // 2: clean left press and release
        applyStimulus(1'b1, 1'b0, 1'b0);
        expectSteady("t2_press_wait", 6, 3'b000);
        expectChange("t2_left_on", 3'b001);
        expectSteady("t2_left_hold", 2, 3'b001);
        applyStimulus(1'b0, 1'b0, 1'b0);
        expectSteady("t2_release_wait", 6, 3'b001);
        expectChange("t2_left_off", 3'b000);
        expectSteady("t2_idle_hold", 2, 3'b000);

        // 3: contact bounce on the left lever before it settles
        applyStimulus(1'b1, 1'b0, 1'b0);
        expectSteady("t3_bounce", 1, 3'b000);
        applyStimulus(1'b0, 1'b0, 1'b0);
        expectSteady("t3_bounce", 1, 3'b000);
        applyStimulus(1'b1, 1'b0, 1'b0);
        expectSteady("t3_bounce", 1, 3'b000);
        applyStimulus(1'b0, 1'b0, 1'b0);
        expectSteady("t3_bounce", 1, 3'b000);
        applyStimulus(1'b1, 1'b0, 1'b0);
        expectSteady("t3_settle_wait", 6, 3'b000);
        expectChange("t3_left_on", 3'b001);
        expectSteady("t3_left_hold", 2, 3'b001);

        // 4: right added while left held -> hazard, then left released -> right
        applyStimulus(1'b1, 1'b1, 1'b0);
        expectSteady("t4_both_wait", 6, 3'b001);
        expectChange("t4_left_to_haz", 3'b100);
        expectSteady("t4_haz_hold", 1, 3'b100);
        applyStimulus(1'b0, 1'b1, 1'b0);
        expectSteady("t4_drop_left_wait", 6, 3'b100);
        expectChange("t4_haz_to_right", 3'b010);
        expectSteady("t4_right_hold", 1, 3'b010);
        applyStimulus(1'b0, 1'b0, 1'b0);
        expectSteady("t4_drop_right_wait", 6, 3'b010);
        expectChange("t4_right_off", 3'b000);

        // 5: 3-cycle hazard pulse is rejected, 4-cycle pulse is accepted
        applyStimulus(1'b0, 1'b0, 1'b1);
        expectSteady("t5_short_pulse", 3, 3'b000);
        applyStimulus(1'b0, 1'b0, 1'b0);
        expectSteady("t5_short_reject", 10, 3'b000);
        applyStimulus(1'b0, 1'b0, 1'b1);
        expectSteady("t5_long_pulse", 4, 3'b000);
        applyStimulus(1'b0, 1'b0, 1'b0);
        expectSteady("t5_long_wait", 2, 3'b000);
        expectChange("t5_haz_on", 3'b100);
        expectSteady("t5_haz_hold", 3, 3'b100);
        expectChange("t5_haz_off", 3'b000);
        expectSteady("t5_idle_hold", 2, 3'b000);

        // 6: async reset in the middle of a left debounce while right is showing
        applyStimulus(1'b0, 1'b1, 1'b0);
        expectSteady("t6_right_wait", 6, 3'b000);
        expectChange("t6_right_on", 3'b010);
        applyStimulus(1'b1, 1'b0, 1'b0);
        expectSteady("t6_mid_debounce", 3, 3'b010);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("t6_async_clear", 3'b000, 1'b0);
        expectSteady("t6_reset_edge", 1, 3'b000);
        rst = 1'b1;
        expectSteady("t6_full_latency", 6, 3'b000);
        expectChange("t6_left_on", 3'b001);
        expectSteady("t6_left_hold", 2, 3'b001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
